bcd_entrada_operandos: RTL and testbench

- Keypad/remote entry sequencer that sits directly upstream of the sign-magnitude ALU.
- Accepts decoded key codes (digits, sign toggle, operator, enter, clear) and accumulates two decimal operands of up to two BCD digits each.
- Converts each operand to binary and presents A, B and op in the ALU input format: 8-bit sign-magnitude, bit 7 = sign, bits 6:0 = magnitude; op 0 = add, 1 = subtract.
- Emits a one-cycle ready pulse when a complete operation has been committed.

---
 rtl/bcd_entrada_operandos_pkg.sv | 29 ++
 rtl/bcd_entrada_operandos_bcd2bin_2d.sv | 18 +
 rtl/bcd_entrada_operandos.sv | 174 +++++++++++++++++
 tb/tb_bcd_entrada_operandos.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bcd_entrada_operandos_pkg.sv
// Shared constants for the keypad operand-entry sequencer and the downstream ALU.
// Key codes, entry states, operator encoding and the sign-magnitude packing helper.
package bcd_entrada_operandos_pkg;

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_ADD   = 4'hB;
    localparam logic [3:0] KEY_SUB   = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_BAD  = 2'd3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic logic is_digit(input logic [3:0] code);
        return (code < 4'd10);
    endfunction

    // A zero magnitude is always packed as +0 so the ALU never sees 0x80.
    function automatic logic [7:0] sign_mag(input logic sign, input logic [6:0] mag);
        return {sign & (mag != 7'd0), mag};
    endfunction

endpackage

// File: rtl/bcd_entrada_operandos_bcd2bin_2d.sv
// Two-digit BCD to 7-bit binary magnitude (0..99), purely combinational.
module bcd2bin_2d
    import bcd_entrada_operandos_pkg::*;
(
    input  logic [7:0] bcd,
    output logic [6:0] mag
);

    logic [6:0] tens_s;
    logic [6:0] units_s;

    assign tens_s  = {3'b000, bcd[7:4]};
    assign units_s = {3'b000, bcd[3:0]};

    // tens*10 built from shifts: 8t + 2t + u
    assign mag = (tens_s << 3) + (tens_s << 1) + units_s;

endmodule

// File: rtl/bcd_entrada_operandos.sv
// Keypad entry sequencer: collects two signed BCD operands and an operator,
// then commits them in ALU sign-magnitude format with a one-cycle ready pulse.
module bcd_entrada_operandos
    import bcd_entrada_operandos_pkg::*;
#(
    parameter int MAX_DIGITS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       op,
    output logic       ready,
    output logic       err,
    output logic [1:0] state,
    output logic [7:0] entry_bcd,
    output logic       entry_sign
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    logic [1:0] state_r,       state_s;
    logic [7:0] entry_bcd_r,   entry_bcd_s;
    logic       entry_sign_r,  entry_sign_s;
    logic [1:0] digit_count_r, digit_count_s;
    logic [7:0] a_buf_r,       a_buf_s;
    logic       op_latch_r,    op_latch_s;
    logic [7:0] a_r,           a_s;
    logic [7:0] b_r,           b_s;
    logic       op_r,          op_s;
    logic       ready_r,       ready_s;
    logic       err_r,         err_s;

    logic [6:0] entry_mag_s;
    logic [7:0] entry_sm_s;

    bcd2bin_2d u_bcd2bin (
        .bcd (entry_bcd_r),
        .mag (entry_mag_s)
    );

    assign entry_sm_s = sign_mag(entry_sign_r, entry_mag_s);

    // Next-state and next-output decode for one sampled key.
    always_comb begin
        state_s       = state_r;
        entry_bcd_s   = entry_bcd_r;
        entry_sign_s  = entry_sign_r;
        digit_count_s = digit_count_r;
        a_buf_s       = a_buf_r;
        op_latch_s    = op_latch_r;
        a_s           = a_r;
        b_s           = b_r;
        op_s          = op_r;
        ready_s       = 1'b0;
        err_s         = 1'b0;

        if (state_r == S_BAD) begin
            state_s = S_A;
        end else if (!key_valid) begin
            state_s = state_r;
        end else if (key_code == KEY_CLEAR) begin
            state_s       = S_A;
            entry_bcd_s   = 8'h00;
            entry_sign_s  = 1'b0;
            digit_count_s = 2'd0;
            a_buf_s       = 8'h00;
            op_latch_s    = OP_ADD;
            a_s           = 8'h00;
            b_s           = 8'h00;
            op_s          = OP_ADD;
        end else begin
            case (state_r)
                S_A, S_B: begin
                    if (is_digit(key_code)) begin
                        if (digit_count_r < MAX_CNT) begin
                            entry_bcd_s   = {entry_bcd_r[3:0], key_code};
                            digit_count_s = digit_count_r + 2'd1;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KEY_SIGN: entry_sign_s = ~entry_sign_r;
                            KEY_ADD, KEY_SUB: begin
                                op_latch_s = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
                                // Only the first operator key closes operand A.
                                if (state_r == S_A) begin
                                    a_buf_s       = entry_sm_s;
                                    entry_bcd_s   = 8'h00;
                                    entry_sign_s  = 1'b0;
                                    digit_count_s = 2'd0;
                                    state_s       = S_B;
                                end else begin
                                    state_s = S_B;
                                end
                            end
                            KEY_ENTER: begin
                                if (state_r == S_B) begin
                                    a_s     = a_buf_r;
                                    b_s     = entry_sm_s;
                                    op_s    = op_latch_r;
                                    ready_s = 1'b1;
                                    state_s = S_DONE;
                                end else begin
                                    err_s = 1'b1;
                                end
                            end
                            KEY_NONE: err_s = 1'b0;
                            default:  err_s = 1'b0;
                        endcase
                    end
                end
                S_DONE: begin
                    if (is_digit(key_code)) begin
                        entry_bcd_s   = {4'h0, key_code};
                        entry_sign_s  = 1'b0;
                        digit_count_s = 2'd1;
                        a_buf_s       = 8'h00;
                        op_latch_s    = OP_ADD;
                        state_s       = S_A;
                    end else if ((key_code == KEY_ADD) || (key_code == KEY_SUB) ||
                                 (key_code == KEY_ENTER)) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = 1'b0;
                    end
                end
                default: state_s = S_A;
            endcase
        end
    end

    // State and output registers; reset discards every buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= S_A;
            entry_bcd_r   <= 8'h00;
            entry_sign_r  <= 1'b0;
            digit_count_r <= 2'd0;
            a_buf_r       <= 8'h00;
            op_latch_r    <= OP_ADD;
            a_r           <= 8'h00;
            b_r           <= 8'h00;
            op_r          <= OP_ADD;
            ready_r       <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            entry_bcd_r   <= entry_bcd_s;
            entry_sign_r  <= entry_sign_s;
            digit_count_r <= digit_count_s;
            a_buf_r       <= a_buf_s;
            op_latch_r    <= op_latch_s;
            a_r           <= a_s;
            b_r           <= b_s;
            op_r          <= op_s;
            ready_r       <= ready_s;
            err_r         <= err_s;
        end
    end

    assign a          = a_r;
    assign b          = b_r;
    assign op         = op_r;
    assign ready      = ready_r;
    assign err        = err_r;
    assign state      = state_r;
    assign entry_bcd  = entry_bcd_r;
    assign entry_sign = entry_sign_r;

endmodule

// File: tb/tb_bcd_entrada_operandos.sv
// Directed bench for the operand-entry sequencer: a key/expectation table
// followed by a hand-written asynchronous reset sequence.
module tb_bcd_entrada_operandos;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [7:0] a, b, entry_bcd;
    logic       op, ready, err, entry_sign;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       eop;
        logic       erdy;
        logic       eerr;
        logic [1:0] est;
        logic [7:0] ebcd;
        logic       esign;
    } vec_t;

    vec_t vecs[$];

    bcd_entrada_operandos #(.MAX_DIGITS(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .a          (a),
        .b          (b),
        .op         (op),
        .ready      (ready),
        .err        (err),
        .state      (state),
        .entry_bcd  (entry_bcd),
        .entry_sign (entry_sign)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic kv, input logic [3:0] kc, input logic [7:0] ea,
                                input logic [7:0] eb, input logic eop, input logic erdy,
                                input logic eerr, input logic [1:0] est, input logic [7:0] ebcd,
                                input logic esign);
        vec_t v;
        v.kv = kv; v.kc = kc; v.ea = ea; v.eb = eb; v.eop = eop; v.erdy = erdy;
        v.eerr = eerr; v.est = est; v.ebcd = ebcd; v.esign = esign;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] ea, input logic [7:0] eb,
                         input logic eop, input logic erdy, input logic eerr,
                         input logic [1:0] est, input logic [7:0] ebcd, input logic esign);
        checks++;
        if ({a, b, op, ready, err, state, entry_bcd, entry_sign} !==
            {ea, eb, eop, erdy, eerr, est, ebcd, esign}) begin
            failures++;
            $display("FAIL %s: got a=%h b=%h op=%b rdy=%b err=%b st=%0d bcd=%h sg=%b, want a=%h b=%h op=%b rdy=%b err=%b st=%0d bcd=%h sg=%b",
                     name, a, b, op, ready, err, state, entry_bcd, entry_sign,
                     ea, eb, eop, erdy, eerr, est, ebcd, esign);
        end
    endtask

    task automatic press(input logic kv, input logic [3:0] kc);
        @(negedge clock);
        key_valid = kv;
        key_code  = kc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //             kv    kc     a      b     op    rdy   err   st    bcd    sg
        // 4,2,B,A,7,D then idle, then 6 from S_DONE, then clear
        vecs.push_back(mk(1'b1, 4'h4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h04, 1'b0));
        vecs.push_back(mk(1'b1, 4'h2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h42, 1'b0));
        vecs.push_back(mk(1'b1, 4'hB, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'hA, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b1));
        vecs.push_back(mk(1'b1, 4'h7, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h07, 1'b1));
        vecs.push_back(mk(1'b1, 4'hD, 8'h2A, 8'h87, 1'b0, 1'b1, 1'b0, 2'd2, 8'h07, 1'b1));
        vecs.push_back(mk(1'b0, 4'h0, 8'h2A, 8'h87, 1'b0, 1'b0, 1'b0, 2'd2, 8'h07, 1'b1));
        vecs.push_back(mk(1'b1, 4'h6, 8'h2A, 8'h87, 1'b0, 1'b0, 1'b0, 2'd0, 8'h06, 1'b0));
        vecs.push_back(mk(1'b1, 4'hE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0));
        // 1,2,3 overflow; idle; E,9,9,C,0,D
        vecs.push_back(mk(1'b1, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 4'h2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h12, 1'b0));
        vecs.push_back(mk(1'b1, 4'h3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h12, 1'b0));
        vecs.push_back(mk(1'b0, 4'h3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h12, 1'b0));
        vecs.push_back(mk(1'b1, 4'hE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'h9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h09, 1'b0));
        vecs.push_back(mk(1'b1, 4'h9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h99, 1'b0));
        vecs.push_back(mk(1'b1, 4'hC, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'hD, 8'h63, 8'h00, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0));
        // E,A,C,A,5,D: negative zero A, then S_DONE sign/op/ignored keys
        vecs.push_back(mk(1'b1, 4'hE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'hA, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1));
        vecs.push_back(mk(1'b1, 4'hC, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'hA, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b1));
        vecs.push_back(mk(1'b1, 4'h5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h05, 1'b1));
        vecs.push_back(mk(1'b1, 4'hD, 8'h00, 8'h85, 1'b1, 1'b1, 1'b0, 2'd2, 8'h05, 1'b1));
        vecs.push_back(mk(1'b1, 4'hA, 8'h00, 8'h85, 1'b1, 1'b0, 1'b0, 2'd2, 8'h05, 1'b1));
        vecs.push_back(mk(1'b1, 4'hB, 8'h00, 8'h85, 1'b1, 1'b0, 1'b1, 2'd2, 8'h05, 1'b1));
        vecs.push_back(mk(1'b1, 4'hF, 8'h00, 8'h85, 1'b1, 1'b0, 1'b0, 2'd2, 8'h05, 1'b1));
        // E, D rejected in S_A, then 3,B,C,2,D (last operator wins)
        vecs.push_back(mk(1'b1, 4'hE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'hD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'h3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h03, 1'b0));
        vecs.push_back(mk(1'b1, 4'hB, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'hC, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'h2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h02, 1'b0));
        vecs.push_back(mk(1'b1, 4'hD, 8'h03, 8'h02, 1'b1, 1'b1, 1'b0, 2'd2, 8'h02, 1'b0));
        vecs.push_back(mk(1'b1, 4'hF, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 2'd2, 8'h02, 1'b0));

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("after_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].kv, vecs[i].kc);
            check($sformatf("vec%0d_key%h", i, vecs[i].kc), vecs[i].ea, vecs[i].eb,
                  vecs[i].eop, vecs[i].erdy, vecs[i].eerr, vecs[i].est,
                  vecs[i].ebcd, vecs[i].esign);
        end

        // From S_DONE (a=03 b=02 op=1): 5,B,8 then asynchronous reset between edges
        press(1'b1, 4'h5);
        press(1'b1, 4'hB);
        press(1'b1, 4'h8);
        check("pre_reset", 8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 2'd1, 8'h08, 1'b0);
        @(posedge clock);
        #3;
        key_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("async_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        press(1'b1, 4'h1);
        press(1'b1, 4'hB);
        press(1'b1, 4'h1);
        check("post_reset_b1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'h01, 1'b0);
        press(1'b1, 4'hD);
        check("post_reset_commit", 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 2'd2, 8'h01, 1'b0);
        press(1'b0, 4'h0);
        check("post_reset_rdy_drop", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 2'd2, 8'h01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
